// File: rtl/mem_pkg.sv
// Shared types and constants for the icache/dcache line-request arbiter.
package mem_pkg;
   localparam int ADDR_W = 64;
   localparam int LINE_W = 512;
   localparam int OFFS_W = 6;

   typedef logic [LINE_W-1:0] line_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT} arb_state_t;
   typedef enum logic {CL_I, CL_D} client_t;

   localparam addr_t OFFS_MASK = addr_t'((64'd1 << OFFS_W) - 64'd1);

   function automatic addr_t line_addr(input addr_t a);
      return a & ~OFFS_MASK;
   endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// client that was not served last.
module rr_pick2
   import mem_pkg::*;
(
   input  logic    req_i,
   input  logic    req_d,
   input  client_t last,
   output logic    grant_valid,
   output client_t winner
);
   always_comb begin
      grant_valid = req_i | req_d;
      winner      = CL_I;
      if (req_i && req_d) begin
         if (last == CL_D) winner = CL_I;
         else              winner = CL_D;
      end else if (req_d) begin
         winner = CL_D;
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter onto the single memory bus port; one line
// transaction in flight at a time, all outputs registered.
//
//   state    | meaning
//   IDLE     | no transaction; arbitrate sampled client requests
//   BUS_REQ  | bus_request held, waiting for bus_reqack (or early bus_done)
//   BUS_WAIT | request accepted, waiting for bus_done
module mem_arbiter
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_request,
   output logic              i_reqack,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_request,
   output logic              d_reqack,
   input  logic              d_wrenable,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_done,
   output logic              bus_request,
   input  logic              bus_reqack,
   output logic              bus_wrenable,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [LINE_W-1:0] bus_wdata,
   input  logic [LINE_W-1:0] bus_rdata,
   input  logic              bus_done
);
   arb_state_t state_q, state_d;
   client_t    owner_q, owner_d, last_q, last_d;
   logic       i_reqack_q, i_reqack_d, d_reqack_q, d_reqack_d;
   logic       i_done_q, i_done_d, d_done_q, d_done_d;
   line_t      i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic       bus_request_q, bus_request_d, bus_wrenable_q, bus_wrenable_d;
   addr_t      bus_addr_q, bus_addr_d;
   line_t      bus_wdata_q, bus_wdata_d;

   logic       grant_valid;
   client_t    winner;

   rr_pick2 u_pick (
      .req_i       (i_request),
      .req_d       (d_request),
      .last        (last_q),
      .grant_valid (grant_valid),
      .winner      (winner)
   );

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      last_d         = last_q;
      i_reqack_d     = 1'b0;
      d_reqack_d     = 1'b0;
      i_done_d       = 1'b0;
      d_done_d       = 1'b0;
      i_rdata_d      = i_rdata_q;
      d_rdata_d      = d_rdata_q;
      bus_request_d  = bus_request_q;
      bus_wrenable_d = bus_wrenable_q;
      bus_addr_d     = bus_addr_q;
      bus_wdata_d    = bus_wdata_q;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               owner_d       = winner;
               bus_request_d = 1'b1;
               state_d       = BUS_REQ;
               if (winner == CL_D) begin
                  d_reqack_d     = 1'b1;
                  bus_addr_d     = line_addr(d_addr);
                  bus_wrenable_d = d_wrenable;
                  bus_wdata_d    = d_wdata;
               end else begin
                  i_reqack_d     = 1'b1;
                  bus_addr_d     = line_addr(i_addr);
                  bus_wrenable_d = 1'b0;
                  bus_wdata_d    = '0;
               end
            end
         end
         BUS_REQ, BUS_WAIT: begin
            // bus_done wins over bus_reqack so an early completion closes the transaction
            if (bus_done) begin
               if (owner_q == CL_D) begin
                  d_rdata_d = bus_rdata;
                  d_done_d  = 1'b1;
               end else begin
                  i_rdata_d = bus_rdata;
                  i_done_d  = 1'b1;
               end
               bus_request_d  = 1'b0;
               bus_wrenable_d = 1'b0;
               bus_addr_d     = '0;
               bus_wdata_d    = '0;
               last_d         = owner_q;
               state_d        = IDLE;
            end else if (state_q == BUS_REQ && bus_reqack) begin
               bus_request_d  = 1'b0;
               bus_wrenable_d = 1'b0;
               state_d        = BUS_WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         owner_q        <= CL_I;
         last_q         <= CL_I;
         i_reqack_q     <= 1'b0;
         d_reqack_q     <= 1'b0;
         i_done_q       <= 1'b0;
         d_done_q       <= 1'b0;
         i_rdata_q      <= '0;
         d_rdata_q      <= '0;
         bus_request_q  <= 1'b0;
         bus_wrenable_q <= 1'b0;
         bus_addr_q     <= '0;
         bus_wdata_q    <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         last_q         <= last_d;
         i_reqack_q     <= i_reqack_d;
         d_reqack_q     <= d_reqack_d;
         i_done_q       <= i_done_d;
         d_done_q       <= d_done_d;
         i_rdata_q      <= i_rdata_d;
         d_rdata_q      <= d_rdata_d;
         bus_request_q  <= bus_request_d;
         bus_wrenable_q <= bus_wrenable_d;
         bus_addr_q     <= bus_addr_d;
         bus_wdata_q    <= bus_wdata_d;
      end
   end

   assign i_reqack     = i_reqack_q;
   assign d_reqack     = d_reqack_q;
   assign i_done       = i_done_q;
   assign d_done       = d_done_q;
   assign i_rdata      = i_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign bus_request  = bus_request_q;
   assign bus_wrenable = bus_wrenable_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus and a transaction-level model
// push expectations; a negedge monitor pops and compares.
module tb_mem_arbiter;
   import mem_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b1;
   logic  i_request = 1'b0, i_reqack, i_done;
   addr_t i_addr = '0;
   line_t i_rdata;
   logic  d_request = 1'b0, d_reqack, d_wrenable = 1'b0, d_done;
   addr_t d_addr = '0;
   line_t d_wdata = '0, d_rdata;
   logic  bus_request, bus_reqack = 1'b0, bus_wrenable, bus_done = 1'b0;
   addr_t bus_addr;
   line_t bus_wdata, bus_rdata = '0;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_request(i_request), .i_reqack(i_reqack), .i_addr(i_addr),
      .i_rdata(i_rdata), .i_done(i_done),
      .d_request(d_request), .d_reqack(d_reqack), .d_wrenable(d_wrenable),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .bus_request(bus_request), .bus_reqack(bus_reqack), .bus_wrenable(bus_wrenable),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_done(bus_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      else n_pass++;
   endtask

   function automatic line_t rand_line();
      line_t l;
      for (int k = 0; k < LINE_W / 32; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   function automatic line_t pat_line();
      line_t l;
      for (int k = 0; k < LINE_W / 8; k++) l[8*k +: 8] = 8'(k);
      return l;
   endfunction

   // expectations
   typedef struct {client_t cl; int cyc;} ack_t;
   typedef struct {client_t cl; line_t rdata; int cyc;} done_t;
   typedef struct packed {logic req; logic we; addr_t addr; line_t wdata;} bus_t;
   ack_t    ackq[$];
   done_t   doneq[$];
   bus_t    exp_cur = '0, exp_nxt = '0;
   client_t glog[$];

   // reference model state
   bit      m_busy = 1'b0;
   client_t m_owner = CL_I, m_last = CL_I, m_w = CL_I;

   // client and responder controls
   int    i_cnt = 0, d_cnt = 0, i_gap = 0, d_gap = 0;
   bit    rnd = 1'b0, withdraw_en = 1'b0;
   addr_t i_fix = '0, d_fix = '0;
   bit    d_fix_we = 1'b0;
   line_t d_fix_wdata = '0;
   int    rsp_ack = 0, rsp_done = 0;
   bit    rsp_pat = 1'b0;
   bit    r_busy = 1'b0;
   int    r_t = 0, r_ack = 0, r_done = 0, sel = 0;

   always @(posedge clk) begin
      #1;
      // memory responder
      bus_reqack = 1'b0;
      bus_done   = 1'b0;
      bus_rdata  = rand_line();
      if (!r_busy && bus_request) begin
         r_busy = 1'b1;
         r_t    = 0;
         r_ack  = (rsp_ack < 0) ? int'($urandom_range(0, 3)) : rsp_ack;
         if (rsp_done >= 0) r_done = rsp_done;
         else begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2)       r_done = r_ack;
            else if (sel == 2) r_done = int'($urandom_range(0, r_ack));
            else if (sel == 3) r_done = r_ack + int'($urandom_range(15, 25));
            else               r_done = r_ack + int'($urandom_range(1, 6));
         end
      end
      if (r_busy) begin
         if (r_t == r_ack && r_t <= r_done) bus_reqack = 1'b1;
         if (r_t == r_done) begin
            bus_done  = 1'b1;
            bus_rdata = rsp_pat ? pat_line() : rand_line();
            r_busy    = 1'b0;
         end
         r_t++;
      end

      if (!rst_n) begin
         i_request = 1'b0;
         d_request = 1'b0;
         m_busy    = 1'b0;
         m_last    = CL_I;
         exp_cur   = '0;
         exp_nxt   = '0;
         ackq.delete();
         doneq.delete();
      end else begin
         // icache client
         if (i_request && i_reqack) begin
            i_request = 1'b0;
            i_gap = rnd ? int'($urandom_range(0, 3)) : 0;
         end else if (i_request && withdraw_en && $urandom_range(0, 19) == 0) begin
            i_request = 1'b0;
            i_cnt++;
         end else if (!i_request && i_cnt > 0) begin
            if (i_gap > 0) i_gap--;
            else begin
               i_request = 1'b1;
               i_addr = rnd ? {$urandom, $urandom} : i_fix;
               i_cnt--;
            end
         end
         // dcache client
         if (d_request && d_reqack) begin
            d_request = 1'b0;
            d_gap = rnd ? int'($urandom_range(0, 3)) : 0;
         end else if (d_request && withdraw_en && $urandom_range(0, 19) == 0) begin
            d_request = 1'b0;
            d_cnt++;
         end else if (!d_request && d_cnt > 0) begin
            if (d_gap > 0) d_gap--;
            else begin
               d_request  = 1'b1;
               d_addr     = rnd ? {$urandom, $urandom} : d_fix;
               d_wrenable = rnd ? 1'($urandom_range(0, 1)) : d_fix_we;
               d_wdata    = !d_wrenable ? '0 : (rnd ? rand_line() : d_fix_wdata);
               d_cnt--;
            end
         end

         // transaction-level model: what the arbiter must do at the coming edge
         exp_cur = exp_nxt;
         if (!m_busy) begin
            if (i_request || d_request) begin
               if (i_request && d_request) m_w = (m_last == CL_I) ? CL_D : CL_I;
               else                        m_w = d_request ? CL_D : CL_I;
               ackq.push_back('{cl: m_w, cyc: cyc + 1});
               m_busy        = 1'b1;
               m_owner       = m_w;
               exp_nxt.req   = 1'b1;
               exp_nxt.we    = (m_w == CL_D) && d_wrenable;
               exp_nxt.addr  = ((m_w == CL_D) ? d_addr : i_addr) & ~addr_t'(64'h3F);
               exp_nxt.wdata = (m_w == CL_D) ? d_wdata : '0;
            end
         end else if (bus_done) begin
            doneq.push_back('{cl: m_owner, rdata: bus_rdata, cyc: cyc + 1});
            m_busy  = 1'b0;
            m_last  = m_owner;
            exp_nxt = '0;
         end else if (bus_reqack) begin
            exp_nxt.req = 1'b0;
            exp_nxt.we  = 1'b0;
         end
      end
   end

   // monitor
   logic  e_ia, e_da, e_id, e_dd;
   line_t e_ird = '0, e_drd = '0;
   ack_t  a_e;
   done_t d_e;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            e_ird = '0;
            e_drd = '0;
         end else begin
            e_ia = 1'b0; e_da = 1'b0; e_id = 1'b0; e_dd = 1'b0;
            while (ackq.size() > 0 && ackq[0].cyc < cyc) begin
               chk("ack_cycle", LINE_W'(ackq[0].cyc), LINE_W'(cyc));
               void'(ackq.pop_front());
            end
            if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
               a_e = ackq.pop_front();
               e_ia = (a_e.cl == CL_I);
               e_da = (a_e.cl == CL_D);
            end
            chk("i_reqack", LINE_W'(i_reqack), LINE_W'(e_ia));
            chk("d_reqack", LINE_W'(d_reqack), LINE_W'(e_da));
            if (i_reqack) glog.push_back(CL_I);
            if (d_reqack) glog.push_back(CL_D);

            while (doneq.size() > 0 && doneq[0].cyc < cyc) begin
               chk("done_cycle", LINE_W'(doneq[0].cyc), LINE_W'(cyc));
               void'(doneq.pop_front());
            end
            if (doneq.size() > 0 && doneq[0].cyc == cyc) begin
               d_e = doneq.pop_front();
               if (d_e.cl == CL_I) begin e_id = 1'b1; e_ird = d_e.rdata; end
               else                begin e_dd = 1'b1; e_drd = d_e.rdata; end
            end
            chk("i_done", LINE_W'(i_done), LINE_W'(e_id));
            chk("d_done", LINE_W'(d_done), LINE_W'(e_dd));
            chk("i_rdata", i_rdata, e_ird);
            chk("d_rdata", d_rdata, e_drd);

            chk("bus_request", LINE_W'(bus_request), LINE_W'(exp_cur.req));
            chk("bus_wrenable", LINE_W'(bus_wrenable), LINE_W'(exp_cur.we));
            chk("bus_addr", LINE_W'(bus_addr), LINE_W'(exp_cur.addr));
            chk("bus_wdata", bus_wdata, exp_cur.wdata);
         end
      end
   end

   task automatic wait_idle(input int budget, input string nm);
      for (int k = 0; k < budget; k++) begin
         @(posedge clk); #3;
         if (i_cnt == 0 && d_cnt == 0 && !i_request && !d_request && !m_busy &&
             ackq.size() == 0 && doneq.size() == 0) return;
      end
      n_chk++;
      $display("FAIL timeout %s: still busy after %0d cycles, required idle", nm, budget);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_i_reqack"}, LINE_W'(i_reqack), '0);
      chk({nm, "_d_reqack"}, LINE_W'(d_reqack), '0);
      chk({nm, "_i_done"}, LINE_W'(i_done), '0);
      chk({nm, "_d_done"}, LINE_W'(d_done), '0);
      chk({nm, "_i_rdata"}, i_rdata, '0);
      chk({nm, "_d_rdata"}, d_rdata, '0);
      chk({nm, "_bus_request"}, LINE_W'(bus_request), '0);
      chk({nm, "_bus_wrenable"}, LINE_W'(bus_wrenable), '0);
      chk({nm, "_bus_addr"}, LINE_W'(bus_addr), '0);
      chk({nm, "_bus_wdata"}, bus_wdata, '0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   logic [3:0] ord;
   logic [3:0] exp_ord;

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #3;

      // icache read, memory answers after 5 cycles with byte-index pattern
      rsp_ack = 1; rsp_done = 5; rsp_pat = 1'b1;
      i_fix = 64'h1047; i_cnt = 1;
      wait_idle(100, "icache_read");

      // dcache line write
      rsp_ack = 3; rsp_done = 6; rsp_pat = 1'b0;
      d_fix = 64'h2000; d_fix_we = 1'b1; d_fix_wdata = {64{8'hA5}}; d_cnt = 1;
      wait_idle(100, "dcache_write");

      // contention straight after reset: D,I,D,I
      pulse_reset();
      rsp_ack = -1; rsp_done = -1;
      glog.delete();
      i_fix = 64'h3010; d_fix = 64'h4020; d_fix_we = 1'b0;
      i_cnt = 2; d_cnt = 2;
      wait_idle(400, "contention");
      chk("grant_count", LINE_W'(glog.size()), LINE_W'(4));
      ord = '0;
      for (int k = 0; k < glog.size() && k < 4; k++) ord = {ord[2:0], glog[k] == CL_D};
      exp_ord = 4'b1010;
      chk("grant_order", LINE_W'(ord), LINE_W'(exp_ord));

      // bus_reqack and bus_done together, then done before reqack
      rsp_ack = 2; rsp_done = 2; i_cnt = 1;
      wait_idle(100, "early_done_same");
      rsp_ack = 3; rsp_done = 1; d_fix_we = 1'b1; d_cnt = 1;
      wait_idle(100, "early_done_before");

      // dcache request held while icache waits 20 cycles
      rsp_ack = 1; rsp_done = 20; i_cnt = 1;
      repeat (3) @(posedge clk);
      #3 d_cnt = 1;
      wait_idle(200, "held_request");

      // reset in BUS_WAIT, stale bus_done afterwards
      rsp_ack = 1; rsp_done = 12; i_cnt = 1;
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 40 && r_busy; k++) begin @(posedge clk); #3; end
      repeat (2) @(posedge clk);
      #3;
      glog.delete();
      rsp_ack = 0; rsp_done = 3;
      i_cnt = 1; d_cnt = 1;
      wait_idle(200, "post_reset_arb");
      chk("post_reset_first", LINE_W'(glog.size() > 0 && glog[0] == CL_D), LINE_W'(1));

      // randomized traffic with withdrawn requests
      rnd = 1'b1; withdraw_en = 1'b1; rsp_ack = -1; rsp_done = -1;
      i_cnt = 60; d_cnt = 60;
      wait_idle(6000, "random");
      withdraw_en = 1'b0;
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
